// File: rtl/nd_1ton_buf_if.sv
// Toggle-handshake channels of the nd_1ton_buf router node: one input channel and
// NUM_OUT output channels. master = peers (sender and receivers), slave = node.
`timescale 1ns/1ps

interface nd_1ton_buf_if #(
  parameter int unsigned DSZ     = 16,
  parameter int unsigned NUM_OUT = 2
);
  logic                   rcv0_req;
  logic                   rcv0_ack;
  logic [DSZ-1:0]         rcv0_dat;
  logic [NUM_OUT-1:0]     snd_req;
  logic [NUM_OUT-1:0]     snd_ack;
  logic [NUM_OUT*DSZ-1:0] snd_dat;

  modport master (
    output rcv0_req, rcv0_dat, snd_ack,
    input  rcv0_ack, snd_req, snd_dat
  );

  modport slave (
    input  rcv0_req, rcv0_dat, snd_ack,
    output rcv0_ack, snd_req, snd_dat
  );
endinterface

// File: rtl/nd_1ton_buf.sv
// 1-to-NUM_OUT message router with an input FIFO and per-output holding registers.
// Define NS_ND_1TON_SYNC_EN to pass rcv0_req and snd_ack through 2-flop synchronizers.
`timescale 1ns/1ps

`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_EQ_OP
`define NS_EQ_OP 3'd0
`endif
`ifndef NS_NE_OP
`define NS_NE_OP 3'd1
`endif
`ifndef NS_LT_OP
`define NS_LT_OP 3'd2
`endif
`ifndef NS_GT_OP
`define NS_GT_OP 3'd3
`endif
`ifndef NS_LE_OP
`define NS_LE_OP 3'd4
`endif
`ifndef NS_GE_OP
`define NS_GE_OP 3'd5
`endif

module nd_1ton_buf #(
  parameter int unsigned      ASZ     = `NS_ADDRESS_SIZE,
  parameter int unsigned      DSZ     = `NS_DATA_SIZE,
  parameter int unsigned      NUM_OUT = 2,
  parameter int unsigned      DEPTH   = 4,
  parameter logic [23:0]      OPER    = {8{`NS_GT_OP}},
  parameter logic [8*ASZ-1:0] REF_VAL = '0
) (
  input  logic                 i_clk,
  input  logic                 reset,
  output logic                 ready,
  output logic [$clog2(DEPTH):0] fifo_cnt,
  nd_1ton_buf_if.slave         bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = $clog2(NUM_OUT);

  logic               rcv_req_s;
  logic [NUM_OUT-1:0] snd_ack_s;

`ifdef NS_ND_1TON_SYNC_EN
  logic [1:0]         req_sync_q;
  logic [NUM_OUT-1:0] ack_sync1_q;
  logic [NUM_OUT-1:0] ack_sync2_q;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      req_sync_q  <= '0;
      ack_sync1_q <= '0;
      ack_sync2_q <= '0;
    end else begin
      req_sync_q  <= {req_sync_q[0], bus.rcv0_req};
      ack_sync1_q <= bus.snd_ack;
      ack_sync2_q <= ack_sync1_q;
    end
  end

  assign rcv_req_s = req_sync_q[1];
  assign snd_ack_s = ack_sync2_q;
`else
  assign rcv_req_s = bus.rcv0_req;
  assign snd_ack_s = bus.snd_ack;
`endif

  function automatic logic pred(input logic [2:0] op, input logic [ASZ-1:0] a,
                                input logic [ASZ-1:0] b);
    logic r;
    r = 1'b0;
    case (op)
      `NS_EQ_OP: r = (a == b);
      `NS_NE_OP: r = (a != b);
      `NS_LT_OP: r = (a < b);
      `NS_GT_OP: r = (a > b);
      `NS_LE_OP: r = (a <= b);
      `NS_GE_OP: r = (a >= b);
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  logic [DSZ-1:0]         mem_q [DEPTH];
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [CW-1:0]          cnt_q;
  logic                   rcv_ack_q;
  logic [NUM_OUT-1:0]     snd_req_q;
  logic [NUM_OUT*DSZ-1:0] snd_dat_q;
  logic                   ready_q;

  logic [DSZ-1:0] head;
  logic [DW-1:0]  dest;
  logic           push;
  logic           pop;

  assign head = mem_q[rd_ptr_q];

  // Scan downwards so the lowest matching output index wins.
  always_comb begin
    dest = '0;
    for (int k = NUM_OUT - 1; k >= 1; k--) begin
      if (pred(OPER[3*k +: 3], head[ASZ-1:0], REF_VAL[ASZ*k +: ASZ])) begin
        dest = DW'(k);
      end
    end
  end

  // Both decisions use pre-edge state: a full FIFO never accepts on the cycle it pops.
  assign push = (rcv_req_s != rcv_ack_q) && (cnt_q < CW'(DEPTH));
  assign pop  = (cnt_q != '0) && (snd_req_q[dest] == snd_ack_s[dest]);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.rcv0_dat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      rcv_ack_q <= 1'b0;
      snd_req_q <= '0;
      snd_dat_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b1;
      if (push) begin
        wr_ptr_q  <= wr_ptr_q + PW'(1);
        rcv_ack_q <= ~rcv_ack_q;
      end
      if (pop) begin
        rd_ptr_q                   <= rd_ptr_q + PW'(1);
        snd_req_q[dest]            <= ~snd_req_q[dest];
        snd_dat_q[DSZ*dest +: DSZ] <= head;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

  assign bus.rcv0_ack = rcv_ack_q;
  assign bus.snd_req  = snd_req_q;
  assign bus.snd_dat  = snd_dat_q;
  assign fifo_cnt     = cnt_q;
  assign ready        = ready_q;

endmodule
